// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns byte/half/word EX requests into word accesses on a
// single-port synchronous RAM (1-cycle read latency), with read-modify-write for sub-word stores.
module lsu_mem_initiator #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W+1:0]   addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [4:0]          rd_q;
  logic [31:0]         merge_q;
  logic                accept;
  logic                unused_addr;

  // Upper address bits wrap modulo the RAM size.
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    logic [31:0]        r;
    b  = word[8*off +: 8];
    h  = word[16*off[1] +: 16];
    bs = 32'(b);
    hs = 32'(h);
    case (size)
      2'b00:   r = uns ? {24'h0, b} : bs;
      2'b01:   r = uns ? {16'h0, h} : hs;
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[8*off +: 8] = wdata[7:0];
    else               r[16*off[1] +: 16] = wdata[15:0];
    return r;
  endfunction

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0]))  state_nxt = RESP;
          else if (req_we && req_size == 2'b10)     state_nxt = WR;
          else                                      state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rd_q      <= '0;
      merge_q   <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W+1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        // Errors skip the RAM entirely, so their response is formed right at accept.
        if (misaligned(req_size, req_addr[1:0])) begin
          resp_data <= '0;
          resp_rd   <= req_we ? 5'd0 : req_rd;
          resp_err  <= 1'b1;
        end
      end
      if (state == CAP) begin
        if (we_q) begin
          merge_q <= merge_store(mem_rdata, wdata_q, size_q, addr_q[1:0]);
        end else begin
          resp_data <= extend_load(mem_rdata, size_q, addr_q[1:0], uns_q);
          resp_rd   <= rd_q;
          resp_err  <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_data <= '0;
        resp_rd   <= '0;
        resp_err  <= 1'b0;
      end
    end
  end

  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = (size_q == 2'b10) ? wdata_q : merge_q;
  assign mem_re     = (state == RD);
  assign mem_we     = (state == WR) && !reset;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign req_ready  = (state == IDLE);

endmodule
